alu_muldiv: RTL and testbench
=============================

// Module: alu_muldiv
// PURPOSE
//   Multi-cycle multiply/divide unit beside the combinational EX-stage ALU.
//   Executes MULT, MULTU, DIV and DIVU iteratively, one bit per cycle, and owns the architectural HI/LO registers.
//   MTHI and MTLO write HI/LO directly; MFHI and MFLO read o_hi/o_lo.
//   Operand width is parametrised; the pipeline stalls on o_busy.
// PARAMETERS
//   SIZEDATA  32  operand and HI/LO width (>=4, even)
//   SIZEOP    3   width of i_op
// PORTS
//   i_clock   in   1          clock; all state updates on rising edge
//   i_reset   in   1          synchronous, active-high reset
//   i_start   in   1          request; accepted only in IDLE
//   i_op      in   SIZEOP     0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO, others=NOP
//   i_datoa   in   SIZEDATA   rs: multiplicand/dividend, MTHI/MTLO source
//   i_datob   in   SIZEDATA   rt: multiplier/divisor
//   o_busy    out  1          iterative op in flight
//   o_done    out  1          one-cycle pulse: HI/LO hold the new result
//   o_divzero out  1          sticky; set by DIV/DIVU with divisor 0, cleared by the next accepted start
//   o_hi      out  SIZEDATA   HI register
//   o_lo      out  SIZEDATA   LO register
// BEHAVIOUR
//   Reset:
//   - o_busy=0, o_done=0, o_divzero=0, o_hi=0, o_lo=0; FSM goes to IDLE.
//   - A reset asserted mid-operation aborts the op and discards the partial result.
//   FSM states:
//   - IDLE: on i_start with op 0-3, latch the operands and go to CALC.
//   - CALC: runs SIZEDATA cycles, driven by a down-counter.
//   - FIX: one cycle of sign correction, then write HI/LO.
//   - DONE: o_done=1 for one cycle, then return to IDLE.
//   Timing and handshake:
//   - o_busy is high in CALC, FIX and DONE.
//   - Start accepted at edge E0: HI/LO are written and o_done rises at edge E0+SIZEDATA+2, so latency is SIZEDATA+2 cycles.
//   - i_start while o_busy is ignored; there is no queueing.
//   - i_start is not accepted in the DONE cycle.
//   MTHI/MTLO:
//   - Accepted in IDLE; o_hi (or o_lo) = i_datoa at the accepting edge.
//   - o_done pulses the following cycle; o_busy stays 0.
//   - HI/LO keep their old values during CALC and are updated only at the FIX->DONE edge.
//   Signed ops (MULT, DIV):
//   - Operands are converted to magnitudes.
//   - The product is negated if the operand signs differ.
//   - The quotient is negated if the signs differ; the remainder takes the dividend's sign.
//   Unsigned ops: operands are used as-is; no correction in FIX.
//   MULT/MULTU:
//   - Shift-add over SIZEDATA iterations into a 2*SIZEDATA-bit product.
//   - {HI,LO} = product.
//   DIV/DIVU:
//   - Restoring division over SIZEDATA iterations.
//   - LO = quotient, HI = remainder.
//   Divide by zero:
//   - Full latency is still taken.
//   - LO = all ones, HI = dividend (i_datoa as latched); o_divzero is set.
//   DIV overflow (most-negative / -1): LO = most-negative value, HI = 0; no flag.
//   i_op values 6-7 with i_start: no state change and no o_done.
// TESTING
//   MULT 0xFFFFFFFE * 3 -> after 34 cycles: o_hi=0xFFFFFFFF, o_lo=0xFFFFFFFA, one o_done pulse.
//   MULTU 0xFFFFFFFF * 0xFFFFFFFF -> o_hi=0xFFFFFFFE, o_lo=0x00000001.
//   DIV -7 / 2 -> o_lo=0xFFFFFFFD (-3), o_hi=0xFFFFFFFF (-1).
//   DIVU 100 / 0 -> o_lo=0xFFFFFFFF, o_hi=100, o_divzero=1.
//   DIV 0x80000000 / 0xFFFFFFFF -> o_lo=0x80000000, o_hi=0.
//   MTHI 0x1234 then MTLO 0x5678 -> o_hi=0x1234, o_lo=0x5678, each with o_done one cycle later.
//   MULT in flight, second i_start -> ignored, only the first result appears.
//   i_reset at cycle 10 of a DIV -> next cycle all outputs are 0 and the FSM is in IDLE.

Source files
------------

// File: rtl/alu_muldiv.sv
// ----------------------------------------------------------------------------
// alu_muldiv
//   Iterative multiply/divide unit that sits beside the EX-stage ALU and owns
//   the architectural HI/LO registers. MULT/MULTU use shift-add and DIV/DIVU use
//   restoring division, one bit per cycle. Signed operations work on operand
//   magnitudes and fix the signs afterwards. MTHI/MTLO write HI/LO directly.
//
// Ports
//   i_clock    clock, all state updates on the rising edge
//   i_reset    synchronous active-high reset
//   i_start    operation request, accepted only while idle
//   i_op       0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO, other codes are NOPs
//   i_datoa    rs: multiplicand / dividend, MTHI/MTLO source
//   i_datob    rt: multiplier / divisor
//   o_busy     iterative operation in flight (CALC, FIX, DONE)
//   o_done     one-cycle pulse, HI/LO hold the new result
//   o_divzero  sticky divide-by-zero flag, cleared by the next accepted start
//   o_hi       HI register
//   o_lo       LO register
// ----------------------------------------------------------------------------
module alu_muldiv #(
    parameter int unsigned SIZEDATA = 32,
    parameter int unsigned SIZEOP   = 3
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [SIZEOP-1:0]   i_op,
    input  logic [SIZEDATA-1:0] i_datoa,
    input  logic [SIZEDATA-1:0] i_datob,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_divzero,
    output logic [SIZEDATA-1:0] o_hi,
    output logic [SIZEDATA-1:0] o_lo
);

    localparam int unsigned N  = SIZEDATA;
    localparam int unsigned CW = $clog2(SIZEDATA + 1);

    localparam logic [SIZEOP-1:0] OP_MULT  = SIZEOP'(0);
    localparam logic [SIZEOP-1:0] OP_MULTU = SIZEOP'(1);
    localparam logic [SIZEOP-1:0] OP_DIV   = SIZEOP'(2);
    localparam logic [SIZEOP-1:0] OP_DIVU  = SIZEOP'(3);
    localparam logic [SIZEOP-1:0] OP_MTHI  = SIZEOP'(4);
    localparam logic [SIZEOP-1:0] OP_MTLO  = SIZEOP'(5);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    // acc_hi: running product high half / partial remainder
    // acc_lo: multiplier shifting out / dividend shifting out, quotient in
    logic [N-1:0]    acc_hi;
    logic [N-1:0]    acc_lo;
    logic [N-1:0]    opb;        // multiplicand or divisor magnitude
    logic [N-1:0]    a_raw;      // dividend as latched, for the div-by-zero HI
    logic            is_div;
    logic            neg_res;    // negate product / quotient
    logic            neg_rem;    // negate remainder (dividend was negative)
    logic            div_zero;

    // Operand decode and magnitude conversion at the accepting edge
    logic            op_iter;
    logic            op_signed;
    logic            op_isdiv;
    logic [N-1:0]    a_mag;
    logic [N-1:0]    b_mag;

    always_comb begin
        op_iter   = 1'b0;
        op_signed = 1'b0;
        op_isdiv  = 1'b0;
        if (i_op == OP_MULT || i_op == OP_MULTU || i_op == OP_DIV || i_op == OP_DIVU)
            op_iter = 1'b1;
        if (i_op == OP_MULT || i_op == OP_DIV)
            op_signed = 1'b1;
        if (i_op == OP_DIV || i_op == OP_DIVU)
            op_isdiv = 1'b1;
        a_mag = i_datoa;
        b_mag = i_datob;
        if (op_signed && i_datoa[N-1])
            a_mag = ~i_datoa + N'(1);
        if (op_signed && i_datob[N-1])
            b_mag = ~i_datob + N'(1);
    end

    // One shift-add multiply step
    logic [N:0]      mul_sum;
    logic [N-1:0]    mul_hi;
    logic [N-1:0]    mul_lo;

    always_comb begin
        mul_sum = {1'b0, acc_hi};
        if (acc_lo[0])
            mul_sum = {1'b0, acc_hi} + {1'b0, opb};
        mul_hi = mul_sum[N:1];
        mul_lo = {mul_sum[0], acc_lo[N-1:1]};
    end

    // One restoring-division step; the remainder stays below the divisor,
    // so the N-bit truncation of the difference is exact
    logic [N:0]      div_sh;
    logic            div_ge;
    logic [N-1:0]    div_diff;
    logic [N-1:0]    div_hi;
    logic [N-1:0]    div_lo;

    always_comb begin
        div_sh   = {acc_hi, acc_lo[N-1]};
        div_ge   = (div_sh >= {1'b0, opb});
        div_diff = N'(div_sh - {1'b0, opb});
        div_hi   = div_ge ? div_diff : div_sh[N-1:0];
        div_lo   = {acc_lo[N-2:0], div_ge};
    end

    // Sign correction and special cases applied in FIX
    logic [2*N-1:0]  prod_fix;
    logic [N-1:0]    fix_hi;
    logic [N-1:0]    fix_lo;

    always_comb begin
        prod_fix = {acc_hi, acc_lo};
        if (neg_res)
            prod_fix = ~{acc_hi, acc_lo} + (2*N)'(1);
        if (!is_div) begin
            fix_hi = prod_fix[2*N-1:N];
            fix_lo = prod_fix[N-1:0];
        end else if (div_zero) begin
            fix_hi = a_raw;
            fix_lo = '1;
        end else begin
            fix_hi = neg_rem ? (~acc_hi + N'(1)) : acc_hi;
            fix_lo = neg_res ? (~acc_lo + N'(1)) : acc_lo;
        end
    end

    // Control FSM, datapath registers and HI/LO
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            opb       <= '0;
            a_raw     <= '0;
            is_div    <= 1'b0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            div_zero  <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_divzero <= 1'b0;
            o_hi      <= '0;
            o_lo      <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (op_iter) begin
                            state     <= ST_CALC;
                            cnt       <= CW'(N);
                            o_busy    <= 1'b1;
                            o_divzero <= 1'b0;
                            is_div    <= op_isdiv;
                            a_raw     <= i_datoa;
                            acc_hi    <= '0;
                            neg_res   <= op_signed && (i_datoa[N-1] ^ i_datob[N-1]);
                            neg_rem   <= op_signed && i_datoa[N-1];
                            div_zero  <= op_isdiv && (i_datob == '0);
                            if (op_isdiv) begin
                                acc_lo <= a_mag;
                                opb    <= b_mag;
                            end else begin
                                acc_lo <= b_mag;
                                opb    <= a_mag;
                            end
                        end else if (i_op == OP_MTHI) begin
                            o_hi      <= i_datoa;
                            o_done    <= 1'b1;
                            o_divzero <= 1'b0;
                        end else if (i_op == OP_MTLO) begin
                            o_lo      <= i_datoa;
                            o_done    <= 1'b1;
                            o_divzero <= 1'b0;
                        end
                    end
                end
                ST_CALC: begin
                    // N iteration cycles, then one terminal-count cycle
                    if (cnt == '0) begin
                        state <= ST_FIX;
                    end else begin
                        cnt <= cnt - CW'(1);
                        if (is_div) begin
                            acc_hi <= div_hi;
                            acc_lo <= div_lo;
                        end else begin
                            acc_hi <= mul_hi;
                            acc_lo <= mul_lo;
                        end
                    end
                end
                ST_FIX: begin
                    o_hi      <= fix_hi;
                    o_lo      <= fix_lo;
                    o_done    <= 1'b1;
                    o_divzero <= div_zero;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// ----------------------------------------------------------------------------
// tb_alu_muldiv
//   Directed and randomized checks of alu_muldiv against an arithmetic
//   reference model (native 64-bit multiply, signed/unsigned divide).
// ----------------------------------------------------------------------------
module tb_alu_muldiv;

    localparam int unsigned N = 32;

    logic          clk;
    logic          i_reset;
    logic          i_start;
    logic [2:0]    i_op;
    logic [N-1:0]  i_datoa;
    logic [N-1:0]  i_datob;
    logic          o_busy;
    logic          o_done;
    logic          o_divzero;
    logic [N-1:0]  o_hi;
    logic [N-1:0]  o_lo;

    alu_muldiv #(.SIZEDATA(N), .SIZEOP(3)) dut (
        .i_clock   (clk),
        .i_reset   (i_reset),
        .i_start   (i_start),
        .i_op      (i_op),
        .i_datoa   (i_datoa),
        .i_datob   (i_datob),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_divzero (o_divzero),
        .o_hi      (o_hi),
        .o_lo      (o_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_hi   = '0;
    logic [31:0] exp_lo   = '0;
    logic        exp_dz   = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: architectural result of one iterative op
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        logic [63:0] p;
        int          sa, sb;
        dz = 1'b0;
        hi = '0;
        lo = '0;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            3'd0: begin
                p  = 64'(longint'(sa) * longint'(sb));
                hi = p[63:32];
                lo = p[31:0];
            end
            3'd1: begin
                p  = {32'd0, a} * {32'd0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            3'd2: begin
                if (b == 0) begin
                    lo = 32'hFFFF_FFFF; hi = a; dz = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000; hi = 32'd0;
                end else begin
                    lo = 32'(sa / sb);
                    hi = 32'(sa % sb);
                end
            end
            default: begin
                if (b == 0) begin
                    lo = 32'hFFFF_FFFF; hi = a; dz = 1'b1;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endtask

    // Issue one iterative op and check latency, hold-off, result and handshake
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit poke);
        logic [31:0] mh, ml;
        logic        mdz;
        int          cycles;
        model(op, a, b, mh, ml, mdz);
        @(negedge clk);
        i_start = 1'b1; i_op = op; i_datoa = a; i_datob = b;
        tick();
        i_start = 1'b0; i_datoa = $urandom; i_datob = $urandom;
        check({tag, " busy"}, 64'(o_busy), 64'(1));
        check({tag, " dz_clr"}, 64'(o_divzero), 64'(0));
        cycles = 0;
        while (o_done !== 1'b1 && cycles < 100) begin
            tick();
            cycles++;
            if (poke && cycles == 3) begin
                i_start = 1'b1; i_op = 3'd4; i_datoa = $urandom;
            end else begin
                i_start = 1'b0;
            end
            if (cycles == 5) begin
                check({tag, " hi_held"}, 64'(o_hi), 64'(exp_hi));
                check({tag, " lo_held"}, 64'(o_lo), 64'(exp_lo));
            end
        end
        check({tag, " latency"}, 64'(cycles), 64'(N + 2));
        exp_hi = mh; exp_lo = ml; exp_dz = mdz;
        check({tag, " hi"}, 64'(o_hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(o_lo), 64'(exp_lo));
        check({tag, " divzero"}, 64'(o_divzero), 64'(exp_dz));
        check({tag, " busy_done"}, 64'(o_busy), 64'(1));
        // A start in the DONE cycle must be ignored
        i_start = 1'b1; i_op = 3'd5; i_datoa = $urandom;
        tick();
        i_start = 1'b0;
        check({tag, " done_pulse"}, 64'(o_done), 64'(0));
        check({tag, " busy_end"}, 64'(o_busy), 64'(0));
        check({tag, " lo_kept"}, 64'(o_lo), 64'(exp_lo));
    endtask

    task automatic run_mt(input string tag, input logic [2:0] op, input logic [31:0] a);
        @(negedge clk);
        i_start = 1'b1; i_op = op; i_datoa = a; i_datob = $urandom;
        tick();
        i_start = 1'b0;
        if (op == 3'd4) exp_hi = a; else exp_lo = a;
        exp_dz = 1'b0;
        check({tag, " done"}, 64'(o_done), 64'(1));
        check({tag, " busy"}, 64'(o_busy), 64'(0));
        check({tag, " hi"}, 64'(o_hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(o_lo), 64'(exp_lo));
        check({tag, " divzero"}, 64'(o_divzero), 64'(0));
        tick();
        check({tag, " done_pulse"}, 64'(o_done), 64'(0));
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            4: return 32'd1;
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_reset = 1'b1; i_start = 1'b0; i_op = '0; i_datoa = '0; i_datob = '0;
        tick();
        tick();
        check("reset busy", 64'(o_busy), 64'(0));
        check("reset done", 64'(o_done), 64'(0));
        check("reset divzero", 64'(o_divzero), 64'(0));
        check("reset hi", 64'(o_hi), 64'(0));
        check("reset lo", 64'(o_lo), 64'(0));
        @(negedge clk);
        i_reset = 1'b0;

        run_op("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("divu_zero", 3'd3, 32'd100, 32'd0, 1'b0);

        // Unsupported op codes leave everything untouched, including the sticky flag
        for (int k = 6; k <= 7; k++) begin
            @(negedge clk);
            i_start = 1'b1; i_op = 3'(k); i_datoa = $urandom; i_datob = $urandom;
            tick();
            i_start = 1'b0;
            check("nop done", 64'(o_done), 64'(0));
            check("nop busy", 64'(o_busy), 64'(0));
            check("nop hi", 64'(o_hi), 64'(exp_hi));
            check("nop lo", 64'(o_lo), 64'(exp_lo));
            check("nop divzero", 64'(o_divzero), 64'(exp_dz));
            tick();
            check("nop done_late", 64'(o_done), 64'(0));
        end

        run_mt("mthi", 3'd4, 32'h0000_1234);
        run_mt("mtlo", 3'd5, 32'h0000_5678);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("div_zero_s", 3'd2, 32'hFFFF_FF00, 32'd0, 1'b0);
        run_op("mult_ignored_start", 3'd0, 32'h0001_2345, 32'hFFFF_0003, 1'b1);

        // Reset during a DIV discards the partial result
        @(negedge clk);
        i_start = 1'b1; i_op = 3'd2; i_datoa = 32'h1234_5678; i_datob = 32'd7;
        tick();
        i_start = 1'b0;
        repeat (9) tick();
        @(negedge clk);
        i_reset = 1'b1;
        tick();
        check("midreset busy", 64'(o_busy), 64'(0));
        check("midreset done", 64'(o_done), 64'(0));
        check("midreset divzero", 64'(o_divzero), 64'(0));
        check("midreset hi", 64'(o_hi), 64'(0));
        check("midreset lo", 64'(o_lo), 64'(0));
        @(negedge clk);
        i_reset = 1'b0;
        exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
        tick();
        check("midreset no_done", 64'(o_done), 64'(0));
        run_mt("after_reset_mtlo", 3'd5, 32'hCAFE_F00D);

        for (int t = 0; t < 40; t++) begin
            run_op("rand", 3'($urandom_range(0, 3)), rand_operand(), rand_operand(),
                   1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
